// File: rtl/jtpopeye_dwnld_src.sv
// Byte-stream to ioctl download source: paces host bytes into one-cycle
// ioctl_wr strobes at least WR_GAP cycles apart and holds downloading for TAIL cycles after the last.
module jtpopeye_dwnld_src #(
  parameter int WR_GAP = 4,
  parameter int TAIL   = 8
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        start,
  input  logic [21:0] len,
  input  logic        abort,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        downloading,
  output logic [21:0] ioctl_addr,
  output logic [7:0]  ioctl_data,
  output logic        ioctl_wr,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP,
    S_TAIL
  } state_t;

  // The strobe cycle is itself the first GAP cycle, hence the -2 / -1 loads.
  localparam logic [3:0] GAP_LOAD  = 4'(WR_GAP - 2);
  localparam logic [7:0] TAIL_LOAD = 8'(TAIL - 1);

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [21:0] idx_q, idx_d;
  logic [21:0] rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  tail_q, tail_d;
  logic        accept;

  assign src_ready   = (state_q == S_WAIT) && !abort;
  assign accept      = src_valid && src_ready;

  assign downloading = dl_q;
  assign ioctl_wr    = wr_q;
  assign done        = done_q;
  assign ioctl_addr  = addr_q;
  assign ioctl_data  = data_q;

  // NOTE: combinational logic uses blocking '=' and assigns every *_d a
  // default first, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    state_d = state_q;
    dl_d    = dl_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    tail_d  = tail_q;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      dl_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && len != '0) begin
            state_d = S_WAIT;
            dl_d    = 1'b1;
            idx_d   = '0;
            rem_d   = len;
          end
        end

        S_WAIT: begin
          if (accept) begin
            data_d  = src_data;
            addr_d  = idx_q;
            wr_d    = 1'b1;
            idx_d   = idx_q + 22'd1;
            rem_d   = rem_q - 22'd1;
            gap_d   = GAP_LOAD;
            tail_d  = TAIL_LOAD;
            state_d = S_GAP;
          end
        end

        S_GAP: begin
          // After the last byte the tail countdown runs from the strobe,
          // so it may expire while the gap is still counting.
          if (rem_q == '0 && tail_q == '0) begin
            state_d = S_IDLE;
            dl_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (rem_q == '0) tail_d = tail_q - 8'd1;
            if (gap_q == '0) state_d = (rem_q != '0) ? S_WAIT : S_TAIL;
            else             gap_d   = gap_q - 4'd1;
          end
        end

        S_TAIL: begin
          if (tail_q == '0) begin
            state_d = S_IDLE;
            dl_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            tail_d = tail_q - 8'd1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_jtpopeye_dwnld_src.sv
// Directed bench for jtpopeye_dwnld_src: cycle table plus multi-cycle
// sequences for stalls, abort, async reset and restart attempts.
module tb_jtpopeye_dwnld_src;

  logic        clk_rom = 1'b0;
  logic        rst;
  logic        start;
  logic [21:0] len;
  logic        abort;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        done;

  jtpopeye_dwnld_src #(.WR_GAP(4), .TAIL(8)) dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .abort       (abort),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .done        (done)
  );

  always #5 clk_rom = ~clk_rom;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  typedef struct {
    int          c;
    logic [21:0] a;
    logic [7:0]  d;
  } strobe_t;

  int      cyc = 0;
  strobe_t strobes[$];
  int      done_cnt = 0;
  int      done_cyc = -1;
  int      fall_cyc = -1;
  logic    dl_prev  = 1'b0;

  always @(posedge clk_rom) cyc <= cyc + 1;

  always @(negedge clk_rom) begin
    if (ioctl_wr) strobes.push_back('{cyc, ioctl_addr, ioctl_data});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (dl_prev && !downloading) fall_cyc <= cyc;
    dl_prev <= downloading;
  end

  task automatic clear_mon();
    strobes.delete();
    done_cnt = 0;
    done_cyc = -1;
    fall_cyc = -1;
  endtask

  // Per-cycle vectors: inputs for the cycle and outputs expected in it.
  typedef struct {
    logic        st;
    logic [21:0] ln;
    logic        v;
    logic [7:0]  d;
    logic        ab;
    logic        e_rdy;
    logic        e_dl;
    logic        e_wr;
    logic        e_done;
    logic [21:0] e_addr;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [21:0] ln, input logic v,
                              input logic [7:0] d, input logic ab, input logic e_rdy,
                              input logic e_dl, input logic e_wr, input logic e_done,
                              input logic [21:0] e_addr, input logic [7:0] e_data);
    vec_t r;
    r.st = st; r.ln = ln; r.v = v; r.d = d; r.ab = ab;
    r.e_rdy = e_rdy; r.e_dl = e_dl; r.e_wr = e_wr; r.e_done = e_done;
    r.e_addr = e_addr; r.e_data = e_data;
    return r;
  endfunction

  task automatic do_start(input logic [21:0] l);
    @(negedge clk_rom);
    start = 1'b1;
    len   = l;
    @(negedge clk_rom);
    start = 1'b0;
    len   = '0;
  endtask

  // Presents bytes in order; optional stall before one byte, abort on one
  // byte (coincident with valid), or a second start while presenting one.
  task automatic send(input logic [7:0] bytes[$], input int stall_idx, input int stall_cyc,
                      input int abort_idx, input int restart_idx);
    int i      = 0;
    int budget = 0;
    bit stalled = 1'b0;
    bit aborted = 1'b0;
    while (i < bytes.size() && !aborted && budget < 2000) begin
      @(negedge clk_rom);
      budget++;
      start = 1'b0;
      len   = '0;
      if (i == stall_idx && !stalled) begin
        src_valid = 1'b0;
        repeat (stall_cyc - 1) @(negedge clk_rom);
        stalled = 1'b1;
        @(negedge clk_rom);
      end
      src_valid = 1'b1;
      src_data  = bytes[i];
      if (i == restart_idx) begin
        start = 1'b1;
        len   = 22'd3;
      end
      #1;
      if (src_ready) begin
        if (i == abort_idx) begin
          abort = 1'b1;
          #1;
          check("abort_gates_ready", 64'(src_ready), 64'd0);
          @(negedge clk_rom);
          abort     = 1'b0;
          src_valid = 1'b0;
          check("abort_clears", 64'({downloading, ioctl_wr}), 64'd0);
          aborted = 1'b1;
        end else begin
          i++;
        end
      end
    end
    check("send_progress", 64'(i >= bytes.size() || aborted), 64'd1);
    @(negedge clk_rom);
    src_valid = 1'b0;
    start     = 1'b0;
    len       = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_rom);
      if (!downloading) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk_rom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic       seen;

    rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0; src_data = '0; src_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_outputs",
             64'({src_ready, downloading, ioctl_wr, done, ioctl_addr, ioctl_data}), 64'd0);
    repeat (3) @(negedge clk_rom);
    rst = 1'b0;

    // len=2 download, valid held: strobes 4 apart, tail of 8, done pulse.
    // Row 0 also has abort with start in IDLE; row 9 a start during TAIL.
    //              st  len    v  d      ab  rdy dl wr dn addr   data
    vecs.push_back(mk(1, 22'd2, 0, 8'h00, 1,  0, 0, 0, 0, 22'd0, 8'h00));
    vecs.push_back(mk(0, 22'd0, 1, 8'h11, 0,  1, 1, 0, 0, 22'd0, 8'h00));
    vecs.push_back(mk(0, 22'd0, 1, 8'h22, 0,  0, 1, 1, 0, 22'd0, 8'h11));
    vecs.push_back(mk(0, 22'd0, 1, 8'h22, 0,  0, 1, 0, 0, 22'd0, 8'h11));
    vecs.push_back(mk(0, 22'd0, 1, 8'h22, 0,  0, 1, 0, 0, 22'd0, 8'h11));
    vecs.push_back(mk(0, 22'd0, 1, 8'h22, 0,  1, 1, 0, 0, 22'd0, 8'h11));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 1, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(1, 22'd5, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 1, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 0, 0, 1, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 1,  0, 0, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 1, 8'h33, 0,  0, 0, 0, 0, 22'd1, 8'h22));
    vecs.push_back(mk(0, 22'd0, 0, 8'h00, 0,  0, 0, 0, 0, 22'd1, 8'h22));

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk_rom);
      start = vecs[r].st; len = vecs[r].ln; src_valid = vecs[r].v;
      src_data = vecs[r].d; abort = vecs[r].ab;
      #1;
      check($sformatf("vec%0d", r),
            64'({src_ready, downloading, ioctl_wr, done, ioctl_addr, ioctl_data}),
            64'({vecs[r].e_rdy, vecs[r].e_dl, vecs[r].e_wr, vecs[r].e_done,
                 vecs[r].e_addr, vecs[r].e_data}));
    end
    @(negedge clk_rom);
    start = 1'b0; len = '0; src_valid = 1'b0; src_data = '0; abort = 1'b0;

    // len=4, valid held, E4 64 A5 46.
    clear_mon();
    q = '{8'hE4, 8'h64, 8'hA5, 8'h46};
    do_start(22'd4);
    send(q, -1, 0, -1, -1);
    wait_idle("basic");
    check("basic_count", 64'(strobes.size()), 64'd4);
    if (strobes.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("basic_addr%0d", k), 64'(strobes[k].a), 64'(k));
        check($sformatf("basic_data%0d", k), 64'(strobes[k].d), 64'(q[k]));
        if (k > 0)
          check($sformatf("basic_gap%0d", k), 64'(strobes[k].c - strobes[k-1].c), 64'd4);
      end
      check("basic_tail", 64'(fall_cyc - strobes[3].c), 64'd8);
    end
    check("basic_done_cnt", 64'(done_cnt), 64'd1);
    check("basic_done_cyc", 64'(done_cyc), 64'(fall_cyc));

    // len=3, valid low for 10 cycles before the second byte.
    clear_mon();
    q = '{8'h01, 8'h02, 8'h03};
    do_start(22'd3);
    send(q, 1, 10, -1, -1);
    wait_idle("stall");
    check("stall_count", 64'(strobes.size()), 64'd3);
    if (strobes.size() == 3) begin
      check("stall_gap1", 64'(strobes[1].c - strobes[0].c), 64'd11);
      check("stall_gap2", 64'(strobes[2].c - strobes[1].c), 64'd4);
      for (int k = 0; k < 3; k++)
        check($sformatf("stall_addr%0d", k), 64'(strobes[k].a), 64'(k));
    end

    // len=0 start is ignored.
    clear_mon();
    do_start(22'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_rom);
      seen = seen | downloading | ioctl_wr | done;
    end
    check("len0_quiet", 64'(seen), 64'd0);

    // len=8, abort together with the third byte.
    clear_mon();
    q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    do_start(22'd8);
    send(q, -1, 0, 2, -1);
    repeat (20) @(negedge clk_rom);
    check("abort_strobes", 64'(strobes.size()), 64'd2);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(downloading), 64'd0);

    // Async reset between edges during GAP of a len=5 download.
    clear_mon();
    q = '{8'hA1};
    do_start(22'd5);
    send(q, -1, 0, -1, -1);
    @(negedge clk_rom);
    #2 rst = 1'b1;
    #1 check("rst_async", 64'({downloading, ioctl_wr, src_ready}), 64'd0);
    #1 rst = 1'b0;
    src_valid = 1'b1;
    src_data  = 8'h77;
    repeat (20) @(negedge clk_rom);
    src_valid = 1'b0;
    check("rst_no_strobe", 64'(strobes.size()), 64'd1);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    q = '{8'h5A};
    do_start(22'd1);
    send(q, -1, 0, -1, -1);
    wait_idle("rst_restart");
    check("rst_new_count", 64'(strobes.size()), 64'd2);
    if (strobes.size() == 2) begin
      check("rst_new_addr", 64'(strobes[1].a), 64'd0);
      check("rst_new_data", 64'(strobes[1].d), 64'h5A);
    end
    check("rst_new_done", 64'(done_cnt), 64'd1);

    // Second start during a len=6 download is ignored.
    clear_mon();
    q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    do_start(22'd6);
    send(q, -1, 0, -1, 2);
    wait_idle("restart");
    repeat (20) @(negedge clk_rom);
    check("restart_count", 64'(strobes.size()), 64'd6);
    if (strobes.size() == 6) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("restart_addr%0d", k), 64'(strobes[k].a), 64'(k));
    end
    check("restart_done", 64'(done_cnt), 64'd1);
    check("restart_idle", 64'(downloading), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
